// File: rtl/zigbee_cordic_pkg.sv
// Shared constants and types for the ZigBee vectoring-mode CORDIC phase detector.
// Angles are in units of 1/2^Z_W of a full turn; x/y carry three headroom bits over the input.
package zigbee_cordic_pkg;

    localparam int IQ_SIZE_D = 5;
    localparam int W_SIZE_D  = 6;
    localparam int ITER_D    = 6;
    localparam int GUARD_D   = 4;

    localparam int XY_W = IQ_SIZE_D + 3;
    localparam int Z_W  = W_SIZE_D + GUARD_D;

    // +half turn and -half turn share one bit pattern modulo a full turn.
    localparam logic signed [Z_W-1:0] HALF_TURN = {1'b1, {(Z_W-1){1'b0}}};

    typedef struct packed {
        logic signed [XY_W-1:0] x;
        logic signed [XY_W-1:0] y;
        logic signed [Z_W-1:0]  z;
    } cordic_t;

    // round(atan(2^-k) * 2^Z_W / 360 deg)
    function automatic logic signed [Z_W-1:0] atan_lut(input int k);
        case (k)
            0:       return Z_W'(128);
            1:       return Z_W'(76);
            2:       return Z_W'(40);
            3:       return Z_W'(20);
            4:       return Z_W'(10);
            5:       return Z_W'(5);
            6:       return Z_W'(3);
            7:       return Z_W'(1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/zigbee_cordic_stage.sv
// One registered CORDIC vectoring micro-rotation with shift index K.
module zigbee_cordic_stage
    import zigbee_cordic_pkg::*;
#(
    parameter int K = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  cordic_t stage_i,
    output cordic_t stage_o
);

    cordic_t                stage_d;
    cordic_t                stage_q;
    logic signed [XY_W-1:0] x_in;
    logic signed [XY_W-1:0] y_in;
    logic signed [Z_W-1:0]  z_in;

    always_comb begin
        x_in    = stage_i.x;
        y_in    = stage_i.y;
        z_in    = stage_i.z;
        stage_d = stage_i;
        // Rotate toward y = 0; both updates use this stage's input values.
        if (!y_in[XY_W-1]) begin
            stage_d.x = x_in + (y_in >>> K);
            stage_d.y = y_in - (x_in >>> K);
            stage_d.z = z_in + atan_lut(K);
        end else begin
            stage_d.x = x_in - (y_in >>> K);
            stage_d.y = y_in + (x_in >>> K);
            stage_d.z = z_in - atan_lut(K);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/zigbee_cordic_top.sv
// Pipelined CORDIC phase detector: Wout = quantised atan2(Qbb, Ibb), latency ITERATIONS+2.
// Optional ZIGBEE_CORDIC_VALID_EN adds in_valid/out_valid travelling with the data.
module zigbee_cordic_top
    import zigbee_cordic_pkg::*;
#(
    parameter int IQ_SIZE    = IQ_SIZE_D,
    parameter int W_SIZE     = W_SIZE_D,
    parameter int ITERATIONS = ITER_D,
    parameter int GUARD      = GUARD_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [IQ_SIZE-1:0] Ibb,
    input  logic signed [IQ_SIZE-1:0] Qbb,
`ifdef ZIGBEE_CORDIC_VALID_EN
    input  logic                      in_valid,
    output logic                      out_valid,
`endif
    output logic signed [W_SIZE-1:0]  Wout
);

    function automatic logic signed [W_SIZE-1:0] round_angle(input logic signed [Z_W-1:0] z);
        return W_SIZE'((z + Z_W'(1 << (GUARD - 1))) >>> GUARD);
    endfunction

    logic signed [XY_W-1:0]  ix;
    logic signed [XY_W-1:0]  qx;
    cordic_t                 pre_d;
    cordic_t                 pre_q;
    logic                    nz_d;
    logic [ITERATIONS:0]     nz_q;
    logic signed [W_SIZE-1:0] wout_q;
    cordic_t                 pipe [ITERATIONS+1];

    // Stage 0: fold the left half-plane onto the right half-plane.
    always_comb begin
        ix      = XY_W'(Ibb);
        qx      = XY_W'(Qbb);
        nz_d    = (Ibb != '0) || (Qbb != '0);
        pre_d.x = ix;
        pre_d.y = qx;
        pre_d.z = '0;
        if (ix[XY_W-1]) begin
            pre_d.x = -ix;
            pre_d.y = -qx;
            pre_d.z = qx[XY_W-1] ? -HALF_TURN : HALF_TURN;
        end
    end

    // A cleared nz flag also forces Wout to 0 while flushed zeros drain out.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            nz_q   <= '0;
            wout_q <= '0;
        end else begin
            pre_q  <= pre_d;
            nz_q   <= {nz_q[ITERATIONS-1:0], nz_d};
            wout_q <= nz_q[ITERATIONS] ? round_angle(pipe[ITERATIONS].z) : '0;
        end
    end

    assign pipe[0] = pre_q;

    // Stages 1..ITERATIONS: micro-rotations.
    for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
        zigbee_cordic_stage #(
            .K(k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .stage_i (pipe[k]),
            .stage_o (pipe[k+1])
        );
    end

    assign Wout = wout_q;

`ifdef ZIGBEE_CORDIC_VALID_EN
    logic [ITERATIONS+1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[ITERATIONS:0], in_valid};
        end
    end

    assign out_valid = vld_q[ITERATIONS+1];
`endif

endmodule

// File: tb/tb_zigbee_cordic_top.sv
// Scoreboard bench for zigbee_cordic_top: expectations queued at drive time, popped at output.
module tb_zigbee_cordic_top;

    localparam int LAT  = 8;
    localparam int TURN = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [4:0] Ibb = '0;
    logic signed [4:0] Qbb = '0;
    logic signed [5:0] Wout;
`ifdef ZIGBEE_CORDIC_VALID_EN
    logic              in_valid = 1'b0;
    logic              out_valid;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    exp_q[$];
    int    tol_q[$];
    int    vld_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    zigbee_cordic_top dut (
        .clk       (clk),
        .rst       (rst),
        .Ibb       (Ibb),
        .Qbb       (Qbb),
`ifdef ZIGBEE_CORDIC_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .Wout      (Wout)
    );

    // Circular comparison on the phase wheel; tol = 0 is an exact match.
    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        int d;
        checks++;
        d = ((((obs - exp) % TURN) + TURN + TURN / 2) % TURN) - TURN / 2;
        if (d > tol || d < -tol) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic int ideal_phase(input int i, input int q);
        real r;
        int  n;
        r = $atan2(real'(q), real'(i)) * real'(TURN) / (2.0 * 3.14159265358979);
        n = $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
        if (n >= TURN / 2) n -= TURN;
        return n;
    endfunction

    // One cycle: compare the output that is due now, then drive and queue the next sample.
    task automatic step(input int i, input int q, input bit r, input bit v,
                        input string tag, input int exp, input int tol);
        int    w;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            w = Wout;
            t = tag_q.pop_front();
            check_val(t, w, exp_q.pop_front(), tol_q.pop_front());
`ifdef ZIGBEE_CORDIC_VALID_EN
            check_val({t, "_vld"}, int'(out_valid), vld_q.pop_front(), 0);
`else
            void'(vld_q.pop_front());
`endif
        end
        Ibb = i[4:0];
        Qbb = q[4:0];
        rst = r;
`ifdef ZIGBEE_CORDIC_VALID_EN
        in_valid = v;
`endif
        if (r) begin
            // Reset empties the pipe: the next LAT outputs must all read 0.
            exp_q.delete(); tol_q.delete(); vld_q.delete(); tag_q.delete();
            for (int n = 0; n < LAT; n++) begin
                exp_q.push_back(0); tol_q.push_back(0); vld_q.push_back(0); tag_q.push_back("rst");
            end
        end else begin
            exp_q.push_back(exp); tol_q.push_back(tol); vld_q.push_back(int'(v)); tag_q.push_back(tag);
        end
    endtask

    task automatic random_burst(input int count);
        int  a;
        int  i;
        int  q;
        real ang;
        for (int n = 0; n < count; n++) begin
            a   = $urandom_range(0, 35999);
            ang = real'(a) * 3.14159265358979 / 18000.0;
            i   = $rtoi(15.0 * $cos(ang));
            q   = $rtoi(15.0 * $sin(ang));
            step(i, q, 1'b0, n[0], "rand", ideal_phase(i, q), 1);
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++) step(0, 0, 1'b1, 1'b0, "rst", 0, 0);

        step( 15,   0, 1'b0, 1'b1, "e0",    0, 0);
        // Floor-shifted micro-rotations land this one on 17; the accuracy bound applies.
        step(  0,  15, 1'b0, 1'b1, "n90",  16, 1);
        step(-15,   0, 1'b0, 1'b1, "w180", -32, 0);
        step(  0, -15, 1'b0, 1'b1, "s90",  -16, 0);
        step( 11,  11, 1'b0, 1'b1, "ne45",   8, 0);
        step(-16, -16, 1'b0, 1'b1, "sw_ext", -24, 0);
        step(  0,   0, 1'b0, 1'b1, "zero",   0, 0);
        step( 15,   0, 1'b0, 1'b0, "e0_b",   0, 0);

        random_burst(5000);
        step(-16, 15, 1'b1, 1'b1, "rst", 0, 0);
        step(-15, 0, 1'b0, 1'b1, "post_rst", -32, 0);
        random_burst(5000);

        for (int n = 0; n < LAT; n++) step(0, 0, 1'b0, 1'b0, "flush", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
